// File: rtl/fetch_unit_if.sv
// Decode-side handshake bundle for fetch_unit: head-of-queue block, its PC and the valid/ready pair.
interface fetch_unit_if #(
    parameter int BLK_W = 64
);
    logic             out_valid;
    logic             out_ready;
    logic [BLK_W-1:0] out_instr_blk;
    logic [31:0]      out_pc;

    modport master (
        output out_valid,
        output out_instr_blk,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr_blk,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC register feeding instruction memory, a small {pc, block} FIFO toward decode, redirect flush.
// Optional macro FETCH_PERF_CNT_EN adds o_stall_cycles, counting cycles blocked by a full queue.
module fetch_unit #(
    parameter int          CORE_WIDTH  = 2,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    output logic [31:0]                     o_pc_addr,
    input  logic [CORE_WIDTH*32-1:0]        i_instruction_blk,
    input  logic                            i_fetch_halt,
    input  logic                            i_redirect_valid,
    input  logic [31:0]                     i_redirect_pc,
    fetch_unit_if.master                    dec,
    output logic [$clog2(QUEUE_DEPTH):0]    o_queue_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                     o_stall_cycles
`endif
);

    localparam int                BLK_W   = CORE_WIDTH * 32;
    localparam int                PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [31:0]       PC_STEP = 32'(4 * CORE_WIDTH);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(QUEUE_DEPTH);

    logic [31:0]      r_pc;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [BLK_W-1:0] r_blk_mem [QUEUE_DEPTH];
    logic [31:0]      r_pc_mem  [QUEUE_DEPTH];

    logic             w_full;
    logic             w_deq;
    logic             w_enq;
    logic [31:0]      w_redirect_pc;

    // Handshake decode; a full queue still accepts when the head leaves in the same cycle.
    always_comb begin
        w_full        = (r_count == DEPTH_C);
        w_deq         = (r_count != {CNT_W{1'b0}}) & dec.out_ready & ~i_redirect_valid;
        w_enq         = ~i_redirect_valid & ~i_fetch_halt & (~w_full | w_deq);
        w_redirect_pc = i_redirect_pc & 32'hFFFF_FFFC;
    end

    // Head entry drives decode directly; redirect masks valid in the same cycle.
    always_comb begin
        dec.out_valid     = (r_count != {CNT_W{1'b0}}) & ~i_redirect_valid;
        dec.out_instr_blk = r_blk_mem[r_rd_ptr];
        dec.out_pc        = r_pc_mem[r_rd_ptr];
        o_pc_addr         = r_pc;
        o_queue_count     = r_count;
    end

    // PC, pointers and occupancy; redirect flushes and reloads ahead of any enqueue/dequeue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_rd_ptr <= {PTR_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (i_redirect_valid) begin
            r_pc     <= w_redirect_pc;
            r_rd_ptr <= {PTR_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_enq) begin
                r_pc     <= r_pc + PC_STEP;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_blk_mem[i] <= {BLK_W{1'b0}};
                r_pc_mem[i]  <= 32'h0000_0000;
            end
        end else if (w_enq) begin
            r_blk_mem[r_wr_ptr] <= i_instruction_blk;
            r_pc_mem[r_wr_ptr]  <= r_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic        w_stall;

    // A stall is a cycle where fetch wanted to enqueue but the queue was full and not draining.
    always_comb begin
        w_stall        = w_full & ~w_deq & ~i_redirect_valid & ~i_fetch_halt;
        o_stall_cycles = r_stall_cycles;
    end

    // Saturating stall counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= 32'h0000_0000;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'h0000_0001;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random traffic against a queue-based model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_addr;
    logic [63:0] instruction_blk;
    logic        fetch_halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0000_0000;
    logic [2:0]  queue_count;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    fetch_unit_if #(.BLK_W(64)) dec_if ();

    fetch_unit #(
        .CORE_WIDTH (2),
        .QUEUE_DEPTH(4),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .o_pc_addr        (pc_addr),
        .i_instruction_blk(instruction_blk),
        .i_fetch_halt     (fetch_halt),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .dec              (dec_if.master),
        .o_queue_count    (queue_count)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_stall_cycles   (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Memory: the word at byte address A holds A/4.
    function automatic logic [63:0] mem_blk(input logic [31:0] a);
        logic [31:0] a1;
        a1 = a + 32'd4;
        return {a1 >> 2, a >> 2};
    endfunction

    always_comb instruction_blk = mem_blk(pc_addr);

    typedef struct {
        logic [31:0] pc;
        logic [63:0] blk;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_stall;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc    = 32'h0000_0000;
        m_stall = 32'h0000_0000;
    endtask

    // Apply inputs, compare outputs against the model, then advance the model and the DUT by one edge.
    task automatic step(input logic halt, input logic redir, input logic [31:0] rpc, input logic rdy);
        bit   m_valid;
        bit   deq;
        bit   enq;
        ent_t e;
        fetch_halt       = halt;
        redirect_valid   = redir;
        redirect_pc      = rpc;
        dec_if.out_ready = rdy;
        #1;
        m_valid = (mq.size() != 0) && !redir;
        check_eq("pc_addr", 64'(pc_addr), 64'(m_pc));
        check_eq("queue_count", 64'(queue_count), 64'(mq.size()));
        check_eq("out_valid", 64'(dec_if.out_valid), 64'(m_valid));
        if (m_valid) begin
            check_eq("out_pc", 64'(dec_if.out_pc), 64'(mq[0].pc));
            check_eq("out_instr_blk", dec_if.out_instr_blk, mq[0].blk);
        end
`ifdef FETCH_PERF_CNT_EN
        check_eq("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
        if (redir) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            deq = m_valid && rdy;
            enq = !halt && (mq.size() < 4 || deq);
            if (mq.size() == 4 && !deq && !halt && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (deq) void'(mq.pop_front());
            if (enq) begin
                e.pc  = m_pc;
                e.blk = mem_blk(m_pc);
                mq.push_back(e);
                m_pc = m_pc + 32'd8;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_pc_addr"}, 64'(pc_addr), 64'h0);
        check_eq({tag, "_valid"}, 64'(dec_if.out_valid), 64'h0);
        check_eq({tag, "_count"}, 64'(queue_count), 64'h0);
        check_eq({tag, "_out_pc"}, 64'(dec_if.out_pc), 64'h0);
        check_eq({tag, "_blk"}, dec_if.out_instr_blk, 64'h0);
`ifdef FETCH_PERF_CNT_EN
        check_eq({tag, "_stall"}, 64'(stall_cycles), 64'h0);
`endif
    endtask

    initial begin
        logic        r_halt;
        logic        r_redir;
        logic        r_rdy;
        logic [31:0] r_rpc;
        dec_if.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Streaming with decode always ready.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Back-pressure from a fresh stream: fills to 4 and PC parks at 0x20.
        step(1'b0, 1'b1, 32'h0000_0000, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("bp_count", 64'(queue_count), 64'd4);
        check_eq("bp_pc", 64'(pc_addr), 64'h20);

        // Full queue drained for one cycle: count holds, PC advances.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("bypass_count", 64'(queue_count), 64'd4);
        check_eq("bypass_pc", 64'(pc_addr), 64'h28);

        // Halt drains the queue without refilling.
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("halt_count", 64'(queue_count), 64'd2);
        step(1'b0, 1'b0, 32'h0, 1'b0);

        // Redirect with 3 entries queued, misaligned target.
        check_eq("pre_redir_count", 64'(queue_count), 64'd3);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        check_eq("redir_pc", 64'(pc_addr), 64'h100);
        check_eq("redir_count", 64'(queue_count), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // PC wrap through zero.
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r_redir = ($urandom_range(0, 15) == 0);
            r_halt  = ($urandom_range(0, 7) == 0);
            r_rdy   = ($urandom_range(0, 9) < 6);
            r_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                   : 32'($urandom);
            step(r_halt, r_redir, r_rpc, r_rdy);
        end

        // Fill, then assert reset between edges.
        step(1'b0, 1'b1, 32'h0000_4000, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("pre_async_count", 64'(queue_count), 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end fetch stage that drives `pc_addr` into the instruction memory and captures the returned `CORE_WIDTH`-instruction block each cycle. Captured blocks go into a small FIFO fetch queue, which decouples the combinational memory read from decode back-pressure. Blocks are presented to decode with a valid/ready handshake. A redirect port from the back end flushes the queue and reloads the PC.

## Interface
- `CORE_WIDTH`, 2: instructions per fetch block; block width `INSTR_BLK_SIZE = CORE_WIDTH*32`.
- `QUEUE_DEPTH`, 4: fetch-queue entries (blocks); power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: PC loaded at reset; word-aligned.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pc_addr` out 32: fetch address to instruction memory; equals the internal PC register.
- `instruction_blk` in `INSTR_BLK_SIZE`: block read combinationally at `pc_addr`; lane i is the word at `pc_addr + 4*i`.
- `fetch_halt` in 1: when 1, no new block is enqueued and the PC holds.
- `redirect_valid` in 1: flush request from the back end.
- `redirect_pc` in 32: new fetch PC; bits [1:0] are ignored and forced to 0.
- `out_valid` out 1: the queue head is valid.
- `out_ready` in 1: decode accepts the head this cycle.
- `out_instr_blk` out `INSTR_BLK_SIZE`: the queue-head block.
- `out_pc` out 32: PC of lane 0 of the head block.
- `queue_count` out `$clog2(QUEUE_DEPTH)+1`: number of occupied entries.

## Operation
- State:
  - PC register.
  - Queue storage of `{pc, blk}` entries.
  - Read and write pointers, each `$clog2(QUEUE_DEPTH)` bits, wrapping modulo `QUEUE_DEPTH`.
  - Occupancy count.
- Dequeue: `deq = out_valid & out_ready & ~redirect_valid`.
- Enqueue: `enq = ~redirect_valid & ~fetch_halt & (count < QUEUE_DEPTH | deq)`.
  - A full queue accepts a new block in the same cycle that decode drains the head.
- On `enq`:
  - Write `{pc, instruction_blk}` at the write pointer.
  - Update `pc <= pc + 4*CORE_WIDTH`, modulo 2^32; 32'hFFFF_FFF8 + 8 wraps to 0.
- Count update:
  - `count += enq - deq`.
  - Simultaneous `enq` and `deq` leaves count unchanged and advances both pointers.
- Redirect has priority over everything:
  - Flush the queue: count=0, both pointers=0.
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - No enqueue and no dequeue that cycle.
  - `out_valid` is forced to 0 combinationally while `redirect_valid=1`.
- `out_valid = (count != 0) & ~redirect_valid`.
- `out_instr_blk` and `out_pc` come straight from the head entry; their value is don't-care when `out_valid=0`.
- Out-of-range memory accesses return NOP blocks from memory; the fetch unit does not inspect contents.

## Timing
- Reset (async assert, sync-style deassert by clock edge):
  - `pc_addr=RESET_PC`, `out_valid=0`, `queue_count=0`, pointers 0.
  - `out_instr_blk` and `out_pc` are 0.
- Latency:
  - A block captured at edge N is visible on `out_*` with `out_valid=1` after edge N, i.e. one cycle.
  - The first block after reset release appears one cycle after the first active edge.
- Throughput: one block per cycle sustained with `out_ready` held high; no bubbles.
- After a redirect at edge N:
  - `pc_addr=redirect_pc` immediately after N.
  - The first redirected block reaches `out_valid` after edge N+1.
- `fetch_halt` with a non-empty queue: the queue still drains normally.
- The output is registered-queue based; there is no combinational path from `out_ready` to `pc_addr`.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds output `stall_cycles` (32 bits, reset 0).
  - Increments on every cycle with `count==QUEUE_DEPTH & ~deq & ~redirect_valid & ~fetch_halt`, i.e. fetch blocked by a full queue.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then stream, with `CORE_WIDTH=2`, `RESET_PC=0`, `out_ready=1`:
  - `out_pc` sequence is 0x0, 0x8, 0x10, …, one per cycle.
  - `out_instr_blk` equals mem words {1,0}, {3,2}, ….
- Back-pressure: `out_ready=0` for 6 cycles:
  - `queue_count` saturates at 4 and `pc_addr` holds at 0x20.
  - Releasing `out_ready` drains 0x0, 0x8, 0x10, 0x18 in order, then 0x20.
- Full-queue bypass: queue full, `out_ready=1` for one cycle → count stays 4 and the PC advances by 8.
- Redirect with `redirect_pc=0x103` while 3 entries are queued:
  - `out_valid=0` that cycle; count becomes 0.
  - `pc_addr=0x100` next cycle.
  - The next `out_pc` is 0x100.
- PC wrap: redirect to 0xFFFF_FFF8 → `out_pc` 0xFFFF_FFF8 then 0x0.
- Async reset asserted mid-stream (between edges):
  - `out_valid` and `queue_count` go to 0 immediately; `pc_addr` goes to `RESET_PC`.
  - With `FETCH_PERF_CNT_EN`, `stall_cycles` returns to 0.
